// File: rtl/uart_tx_fifo.sv
// UART transmitter with a TX FIFO: valid/ready write side, LSB-first serialiser with
// optional parity and one or two stop bits; frame format is latched at frame start.
module uart_tx_fifo #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic [15:0]       cfg_div,
   input  logic              cfg_txen,
   input  logic              cfg_nstop,
   input  logic              cfg_paren,
   input  logic              cfg_parodd,
   input  logic              tx_valid,
   input  logic [DATA_W-1:0] tx_data,
   output logic              tx_ready,
   output logic              uart_txd,
   output logic              tx_busy,
   output logic [LVL_W-1:0]  fifo_level
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned BIT_W = $clog2(DATA_W);
   localparam int unsigned DIV_W = 16;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   typedef struct packed {
      logic [DIV_W-1:0] div;
      logic             nstop;
      logic             paren;
      logic             parodd;
   } frame_cfg_t;

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [LVL_W-1:0]  level_q;
   logic [DATA_W-1:0] head;
   logic              push;
   logic              pop;
   logic              can_launch;
   logic              launch;
   logic              bit_end;

   state_t            state_q,  state_n;
   frame_cfg_t        fcfg_q,   fcfg_n;
   logic [DIV_W-1:0]  baud_q,   baud_n;
   logic [BIT_W-1:0]  bit_q,    bit_n;
   logic [DATA_W-1:0] shift_q,  shift_n;
   logic              par_q,    par_n;
   logic              txd_q,    txd_n;
   logic              busy_q,   busy_n;

   // Counter preload for one bit period; a divisor of 0 behaves as 1.
   function automatic logic [DIV_W-1:0] reload(input logic [DIV_W-1:0] div);
      return (div == '0) ? '0 : div - DIV_W'(1);
   endfunction

   assign tx_ready   = (level_q != LVL_W'(FIFO_DEPTH));
   assign push       = tx_valid && tx_ready;
   assign head       = mem[rd_ptr];
   assign can_launch = cfg_txen && (level_q != '0);
   assign bit_end    = (baud_q == '0);
   assign fifo_level = level_q;
   assign uart_txd   = txd_q;
   assign tx_busy    = busy_q;

   // FIFO storage carries no reset; the pointers alone define the contents.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= tx_data;
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         level_q <= level_q + LVL_W'(push) - LVL_W'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q <= IDLE;
         fcfg_q  <= '0;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         txd_q   <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         fcfg_q  <= fcfg_n;
         baud_q  <= baud_n;
         bit_q   <= bit_n;
         shift_q <= shift_n;
         par_q   <= par_n;
         txd_q   <= txd_n;
         busy_q  <= busy_n;
      end
   end

   // Next-state and next-output logic; a frame launch (pop) overrides the case result.
   always_comb begin
      state_n = state_q;
      fcfg_n  = fcfg_q;
      baud_n  = baud_q;
      bit_n   = bit_q;
      shift_n = shift_q;
      par_n   = par_q;
      txd_n   = txd_q;
      busy_n  = busy_q;
      pop     = 1'b0;
      launch  = 1'b0;

      case (state_q)
         IDLE: begin
            txd_n  = 1'b1;
            busy_n = 1'b0;
            if (can_launch) begin
               launch = 1'b1;
            end
         end
         START: begin
            if (bit_end) begin
               state_n = DATA;
               txd_n   = shift_q[0];
               shift_n = shift_q >> 1;
               bit_n   = '0;
               baud_n  = reload(fcfg_q.div);
            end else begin
               baud_n = baud_q - DIV_W'(1);
            end
         end
         DATA: begin
            if (bit_end) begin
               baud_n = reload(fcfg_q.div);
               if (bit_q == BIT_W'(DATA_W - 1)) begin
                  bit_n = '0;
                  if (fcfg_q.paren) begin
                     state_n = PARITY;
                     txd_n   = par_q;
                  end else begin
                     state_n = STOP;
                     txd_n   = 1'b1;
                  end
               end else begin
                  bit_n   = bit_q + BIT_W'(1);
                  txd_n   = shift_q[0];
                  shift_n = shift_q >> 1;
               end
            end else begin
               baud_n = baud_q - DIV_W'(1);
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_n = STOP;
               txd_n   = 1'b1;
               bit_n   = '0;
               baud_n  = reload(fcfg_q.div);
            end else begin
               baud_n = baud_q - DIV_W'(1);
            end
         end
         STOP: begin
            if (bit_end) begin
               if (fcfg_q.nstop && (bit_q == '0)) begin
                  bit_n  = BIT_W'(1);
                  baud_n = reload(fcfg_q.div);
               end else if (can_launch) begin
                  launch = 1'b1;
               end else begin
                  state_n = IDLE;
                  busy_n  = 1'b0;
                  txd_n   = 1'b1;
                  baud_n  = '0;
                  bit_n   = '0;
               end
            end else begin
               baud_n = baud_q - DIV_W'(1);
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      // Pop the head, snapshot the frame format and drive the start bit.
      if (launch) begin
         pop     = 1'b1;
         state_n = START;
         busy_n  = 1'b1;
         txd_n   = 1'b0;
         shift_n = head;
         par_n   = (^head) ^ cfg_parodd;
         fcfg_n  = '{div: cfg_div, nstop: cfg_nstop, paren: cfg_paren, parodd: cfg_parodd};
         baud_n  = reload(cfg_div);
         bit_n   = '0;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: scoreboard of expected frames decoded by a serial
// receiver, plus cycle-exact latency, length, back-to-back and reset checks.
module tb_uart_tx_fifo;

   logic        clk = 1'b0;
   logic        rst_b;
   logic [15:0] cfg_div;
   logic        cfg_txen, cfg_nstop, cfg_paren, cfg_parodd;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready, uart_txd, tx_busy;
   logic [3:0]  fifo_level;

   logic [15:0] cfg_div_5;
   logic        tx_valid_5;
   logic [4:0]  tx_data_5;
   logic        tx_ready_5, uart_txd_5, tx_busy_5;
   logic [3:0]  fifo_level_5;

   typedef struct {
      logic [7:0] data;
      int         div;
      bit         paren;
      bit         parodd;
      bit         nstop;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic rx_prev = 1'b1;
   bit   rx_gl, rx_ab;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_fifo #(.DATA_W(8), .FIFO_DEPTH(8)) dut (
      .clk(clk), .rst_b(rst_b), .cfg_div(cfg_div), .cfg_txen(cfg_txen),
      .cfg_nstop(cfg_nstop), .cfg_paren(cfg_paren), .cfg_parodd(cfg_parodd),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .uart_txd(uart_txd), .tx_busy(tx_busy), .fifo_level(fifo_level)
   );

   uart_tx_fifo #(.DATA_W(5), .FIFO_DEPTH(8)) dut5 (
      .clk(clk), .rst_b(rst_b), .cfg_div(cfg_div_5), .cfg_txen(1'b1),
      .cfg_nstop(1'b0), .cfg_paren(1'b0), .cfg_parodd(1'b0),
      .tx_valid(tx_valid_5), .tx_data(tx_data_5), .tx_ready(tx_ready_5),
      .uart_txd(uart_txd_5), .tx_busy(tx_busy_5), .fifo_level(fifo_level_5)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   // Sample one bit period starting at the current negedge; flag any change inside it.
   task automatic rx_bit(input int div, output logic v);
      int d = (div < 1) ? 1 : div;
      v = uart_txd;
      if (rst_b !== 1'b1) rx_ab = 1;
      for (int k = 1; k < d; k++) begin
         @(negedge clk);
         if (uart_txd !== v) rx_gl = 1;
         if (rst_b !== 1'b1) rx_ab = 1;
      end
   endtask

   task automatic rx_frame();
      exp_t e;
      logic [7:0] d = '0;
      logic v, p = 1'b0, s1, s2 = 1'b1;
      bit have = (sb.size() != 0);
      chk("rx_frame_expected", 32'(have), 32'd1);
      if (!have) return;
      e = sb.pop_front();
      rx_gl = 0;
      rx_ab = 0;
      rx_bit(e.div, v);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         rx_bit(e.div, v);
         d[i] = v;
      end
      if (e.paren) begin
         @(negedge clk);
         rx_bit(e.div, p);
      end
      @(negedge clk);
      rx_bit(e.div, s1);
      if (e.nstop) begin
         @(negedge clk);
         rx_bit(e.div, s2);
      end
      if (rx_ab) return;
      chk("rx_data", 32'(d), 32'(e.data));
      if (e.paren) chk("rx_parity", 32'(p), 32'((^e.data) ^ e.parodd));
      chk("rx_stop", 32'({s1, s2}), 32'd3);
      chk("rx_bit_stable", 32'(rx_gl), 32'd0);
   endtask

   always begin : rx_mon
      @(negedge clk);
      if (rst_b === 1'b1 && rx_prev === 1'b1 && uart_txd === 1'b0) rx_frame();
      rx_prev = uart_txd;
   end

   // Called at a negedge; holds tx_valid until accepted and queues the expected frame.
   task automatic push(input logic [7:0] d, input int div, input bit pe, input bit po, input bit ns);
      bit   done = 0;
      logic rdy;
      exp_t e;
      tx_valid = 1'b1;
      tx_data  = d;
      for (int i = 0; i < 100000 && !done; i++) begin
         rdy = tx_ready;
         @(posedge clk);
         if (rdy === 1'b1) begin
            done   = 1;
            e.data = d; e.div = div; e.paren = pe; e.parodd = po; e.nstop = ns;
            sb.push_back(e);
         end
         @(negedge clk);
      end
      tx_valid = 1'b0;
      chk("push_accepted", 32'(done), 32'd1);
   endtask

   task automatic busy_run(output int n);
      n = 0;
      while (tx_busy === 1'b1 && n < 40000) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic frame_one(input logic [7:0] d, input int div, input bit pe, input bit po,
                            input bit ns, input int periods, input string tag);
      int n;
      cfg_div = 16'(div); cfg_paren = pe; cfg_parodd = po; cfg_nstop = ns; cfg_txen = 1'b1;
      push(d, div, pe, po, ns);
      chk({tag, "_level_after_push"}, 32'(fifo_level), 32'd1);
      chk({tag, "_txd_before_pop"}, 32'(uart_txd), 32'd1);
      @(negedge clk);
      chk({tag, "_start_bit"}, 32'(uart_txd), 32'd0);
      chk({tag, "_busy_at_pop"}, 32'(tx_busy), 32'd1);
      chk({tag, "_level_after_pop"}, 32'(fifo_level), 32'd0);
      busy_run(n);
      chk({tag, "_frame_clocks"}, 32'(n), 32'(periods * div));
      chk({tag, "_txd_idle"}, 32'(uart_txd), 32'd1);
      chk({tag, "_scoreboard_drained"}, 32'(sb.size()), 32'd0);
   endtask

   task automatic five_bit(input logic [4:0] d, input logic [15:0] div);
      logic [6:0] ev = {1'b1, d, 1'b0};
      cfg_div_5  = div;
      tx_valid_5 = 1'b1;
      tx_data_5  = d;
      @(posedge clk);
      @(negedge clk);
      tx_valid_5 = 1'b0;
      chk("w5_level_after_push", 32'(fifo_level_5), 32'd1);
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         chk("w5_bit", 32'(uart_txd_5), 32'(ev[i]));
      end
      chk("w5_busy_last_clock", 32'(tx_busy_5), 32'd1);
      @(negedge clk);
      chk("w5_busy_done", 32'(tx_busy_5), 32'd0);
      chk("w5_txd_idle", 32'(uart_txd_5), 32'd1);
   endtask

   initial begin
      int c0, c1, n, bad;
      rst_b = 1'b0;
      cfg_div = 16'd869; cfg_txen = 1'b0; cfg_nstop = 1'b0; cfg_paren = 1'b0; cfg_parodd = 1'b0;
      tx_valid = 1'b0; tx_data = '0;
      cfg_div_5 = '0; tx_valid_5 = 1'b0; tx_data_5 = '0;
      repeat (2) @(negedge clk);
      chk("rst_txd", 32'(uart_txd), 32'd1);
      chk("rst_ready", 32'(tx_ready), 32'd1);
      chk("rst_busy", 32'(tx_busy), 32'd0);
      chk("rst_level", 32'(fifo_level), 32'd0);
      rst_b = 1'b1;
      @(negedge clk);
      chk("post_rst_txd", 32'(uart_txd), 32'd1);
      chk("post_rst_level", 32'(fifo_level), 32'd0);

      frame_one(8'hA5, 869, 1'b0, 1'b0, 1'b0, 10, "t_8n1");
      frame_one(8'h07, 16, 1'b1, 1'b0, 1'b1, 12, "t_8e2");
      frame_one(8'h07, 16, 1'b1, 1'b1, 1'b0, 11, "t_8o1");

      five_bit(5'b10110, 16'd0);
      five_bit(5'b01001, 16'd1);

      // FIFO fill with transmit disabled, then drain back-to-back
      cfg_div = 16'd4; cfg_paren = 1'b0; cfg_nstop = 1'b0; cfg_txen = 1'b0;
      for (int i = 0; i < 8; i++) push(8'(8'h30 + i), 4, 1'b0, 1'b0, 1'b0);
      chk("fill_level_full", 32'(fifo_level), 32'd8);
      chk("fill_ready_low", 32'(tx_ready), 32'd0);
      tx_valid = 1'b1;
      tx_data  = 8'hC9;
      repeat (5) @(negedge clk);
      chk("fill_ninth_held", 32'(fifo_level), 32'd8);
      chk("fill_txd_idle", 32'(uart_txd), 32'd1);
      c0 = cyc;
      cfg_txen = 1'b1;
      push(8'hC9, 4, 1'b0, 1'b0, 1'b0);
      n = 0;
      while (tx_busy === 1'b1 && n < 5000) begin
         n++;
         @(negedge clk);
      end
      c1 = cyc;
      chk("fill_back_to_back_clocks", 32'(c1 - c0), 32'(9 * 10 * 4 + 1));
      chk("fill_level_empty", 32'(fifo_level), 32'd0);
      chk("fill_scoreboard_drained", 32'(sb.size()), 32'd0);

      // Mid-frame reconfiguration applies only to the following frame
      cfg_div = 16'd869; cfg_nstop = 1'b0;
      push(8'h3C, 869, 1'b0, 1'b0, 1'b0);
      c0 = cyc;
      push(8'hC3, 434, 1'b0, 1'b0, 1'b1);
      repeat (869 * 3) @(negedge clk);
      cfg_div = 16'd434; cfg_nstop = 1'b1;
      n = 0;
      while (tx_busy === 1'b1 && n < 30000) begin
         n++;
         @(negedge clk);
      end
      c1 = cyc;
      chk("reconf_total_clocks", 32'(c1 - c0), 32'(10 * 869 + 11 * 434 + 1));
      chk("reconf_scoreboard_drained", 32'(sb.size()), 32'd0);

      // Reset in the middle of a frame with bytes still queued
      cfg_div = 16'd20; cfg_nstop = 1'b0; cfg_txen = 1'b0;
      for (int i = 0; i < 5; i++) push(8'(8'h50 + i), 20, 1'b0, 1'b0, 1'b0);
      chk("rstmid_level_queued", 32'(fifo_level), 32'd5);
      cfg_txen = 1'b1;
      repeat (65) @(negedge clk);
      chk("rstmid_busy_before", 32'(tx_busy), 32'd1);
      chk("rstmid_level_before", 32'(fifo_level), 32'd4);
      rst_b = 1'b0;
      #1;
      chk("rstmid_txd", 32'(uart_txd), 32'd1);
      chk("rstmid_busy", 32'(tx_busy), 32'd0);
      chk("rstmid_level", 32'(fifo_level), 32'd0);
      chk("rstmid_ready", 32'(tx_ready), 32'd1);
      sb.delete();
      repeat (3) @(negedge clk);
      rst_b = 1'b1;
      bad = 0;
      repeat (300) begin
         @(negedge clk);
         if (uart_txd !== 1'b1 || tx_busy !== 1'b0) bad++;
      end
      chk("rstmid_no_frames_after", 32'(bad), 32'd0);
      chk("rstmid_level_after", 32'(fifo_level), 32'd0);
      chk("end_scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
